irq_controller: RTL

- Parametrised interrupt controller / CP0 slice for the single-cycle MIPS core.
- Replaces the fixed 3-line, mask-and-disable interrupt logic in the CPU top.
- Captures N interrupt lines, prioritises them, and supplies a vector address for the PC mux.
- Saves the return PC into an EPC, and handles return-from-interrupt (eret) and software mask/enable writes.

---
 rtl/irq_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Parametrised interrupt controller / CP0 slice: edge capture, masking, priority, vector and EPC.
// Define NESTED_IRQ_EN to turn the single EPC register into a NEST_DEPTH-entry {epc, id} stack.
module irq_controller #(
  parameter int unsigned N_IRQ      = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
  parameter int unsigned NEST_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [31:0]      pc_next,
  input  logic             eret,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             ie_we,
  input  logic             ie_wdata,
  output logic             irq_take,
  output logic [31:0]      irq_vector,
  output logic [31:0]      epc_out,
  output logic             eret_valid,
  output logic [4:0]       active_id,
  output logic             in_isr,
  output logic [N_IRQ-1:0] pending_out,
  output logic [N_IRQ-1:0] mask_out,
  output logic             ie_out
);

`ifdef NESTED_IRQ_EN
  localparam int unsigned DEPTH = NEST_DEPTH;
`else
  // Single EPC register; NEST_DEPTH only sizes the nested stack.
  localparam int unsigned DEPTH = (NEST_DEPTH != 0) ? 1 : 1;
`endif
  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic [N_IRQ-1:0] irq_prev_q, pending_q, pending_d, mask_q, elig, clr;
  logic             ie_q, ie_d, slot_ok;
  logic [DW-1:0]    depth_q, depth_d;
  logic [31:0]      epc_q [DEPTH];
  logic [4:0]       id_q  [DEPTH];
  logic [4:0]       id_w, top_id;
  logic [31:0]      top_epc;

  assign elig = pending_q & ~mask_q;

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    id_w = '0;
    for (int k = 0; k < int'(N_IRQ); k++)
      if (elig[k]) id_w = 5'(k);
  end

  // Top of stack: entry depth-1, or zeros when nothing is being serviced.
  always_comb begin
    top_id  = '0;
    top_epc = '0;
    for (int i = 0; i < int'(DEPTH); i++)
      if (int'(depth_q) == i + 1) begin
        top_id  = id_q[i];
        top_epc = epc_q[i];
      end
  end

`ifdef NESTED_IRQ_EN
  assign slot_ok = (depth_q == '0) || ((id_w > top_id) && (int'(depth_q) < int'(DEPTH)));
  assign epc_out = top_epc;
`else
  assign slot_ok = (depth_q == '0);
  assign epc_out = epc_q[0];
`endif

  assign irq_take   = ie_q & (|elig) & ~eret & slot_ok;
  assign eret_valid = eret & (depth_q != '0);
  assign irq_vector = irq_take ? (VEC_BASE + 32'(id_w) * VEC_STRIDE) : 32'h0;
  assign active_id  = top_id;
  assign in_isr     = (depth_q != '0);
  assign pending_out = pending_q;
  assign mask_out    = mask_q;
  assign ie_out      = ie_q;

  always_comb begin
    clr = '0;
    for (int k = 0; k < int'(N_IRQ); k++)
      clr[k] = irq_take && (id_w == 5'(k));
    // A fresh edge on the line being taken re-pends it: set wins over clear.
    pending_d = (pending_q & ~clr) | (irq_in & ~irq_prev_q);

    depth_d = depth_q;
    if (irq_take)        depth_d = depth_q + DW'(1);
    else if (eret_valid) depth_d = depth_q - DW'(1);

    ie_d = ie_q;
`ifndef NESTED_IRQ_EN
    if (irq_take)        ie_d = 1'b0;
    else if (eret_valid) ie_d = 1'b1;
`endif
    if (ie_we) ie_d = ie_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      ie_q       <= 1'b1;
      depth_q    <= '0;
      // NOTE: the EPC stack is reset on purpose; it is small and epc_out must read 0 out of reset.
      for (int i = 0; i < int'(DEPTH); i++) begin
        epc_q[i] <= '0;
        id_q[i]  <= '0;
      end
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      ie_q       <= ie_d;
      depth_q    <= depth_d;
      if (mask_we) mask_q <= mask_wdata;
      for (int i = 0; i < int'(DEPTH); i++)
        if (irq_take && (int'(depth_q) == i)) begin
          epc_q[i] <= pc_next;
          id_q[i]  <= id_w;
        end
    end
  end

endmodule
